// File: rtl/line_port_arbiter_if.sv
// line_port_arbiter_if: cache-side and adaptor-side signals of the line port arbiter.
interface line_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_resp;
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata
  );
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
    output i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata
  );
endinterface

// File: rtl/line_port_arbiter.sv
// line_port_arbiter: shares one registered adaptor line port between I-cache and D-cache.
module line_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter bit RR_EN  = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  line_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;
  state_t            r_state;
  logic              r_m_read, r_m_write, r_i_resp, r_d_resp;
  logic              r_rr_last_d, r_win_d;
  logic [ADDR_W-1:0] r_m_addr;
  logic [LINE_W-1:0] r_m_wdata, r_line;
  logic              w_i_req, w_d_req, w_grant_d;
  assign w_i_req   = bus.i_read;
  assign w_d_req   = bus.d_read | bus.d_write;
  // D wins alone, on fixed priority, or when I held the port last.
  assign w_grant_d = w_d_req & (~w_i_req | ~RR_EN | ~r_rr_last_d);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_m_read    <= 1'b0;
      r_m_write   <= 1'b0;
      r_i_resp    <= 1'b0;
      r_d_resp    <= 1'b0;
      r_rr_last_d <= 1'b0;
      r_win_d     <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_line      <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_i_req | w_d_req) begin
          r_state   <= w_grant_d ? SERVE_D : SERVE_I;
          r_win_d   <= w_grant_d;
          r_m_addr  <= w_grant_d ? bus.d_addr : bus.i_addr;
          r_m_wdata <= w_grant_d ? bus.d_wdata : r_m_wdata;
          r_m_read  <= ~(w_grant_d & bus.d_write);
          r_m_write <= w_grant_d & bus.d_write;
        end
        SERVE_I, SERVE_D: if (bus.m_resp) begin
          r_line      <= r_m_read ? bus.m_rdata : r_line;
          r_m_read    <= 1'b0;
          r_m_write   <= 1'b0;
          r_rr_last_d <= r_win_d;
          r_i_resp    <= ~r_win_d;
          r_d_resp    <= r_win_d;
          r_state     <= DONE;
        end
        DONE: begin
          r_i_resp <= 1'b0;
          r_d_resp <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always @(posedge clk)
    if (reset_n && r_state == IDLE)
      assert (!(bus.d_read && bus.d_write))
        else $warning("d_read and d_write both high; treated as write");
  assign bus.m_read  = r_m_read;
  assign bus.m_write = r_m_write;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.i_resp  = r_i_resp;
  assign bus.d_resp  = r_d_resp;
  assign bus.i_rdata = r_line;
  assign bus.d_rdata = r_line;
endmodule
